// File: rtl/mac_dot_sequencer_if.sv
// Operand, MAC and result bundle for mac_dot_sequencer.
// slave: sequencer side; master: upstream source, MAC and result sink.
interface mac_dot_sequencer_if #(
    parameter int N  = 8,
    parameter int CW = 9
);
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_w;
    logic [N-1:0]    in_x;
    logic            in_last;
    logic [N-1:0]    mac_w;
    logic [N-1:0]    mac_x;
    logic [2*N-1:0]  mac_f;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  out_sum;
    logic [CW-1:0]   out_count;
    logic            out_trunc;

    modport slave (
        input  in_valid, in_w, in_x, in_last,
        input  mac_f, out_ready,
        output in_ready, mac_w, mac_x,
        output out_valid, out_sum, out_count, out_trunc
    );

    modport master (
        output in_valid, in_w, in_x, in_last,
        output mac_f, out_ready,
        input  in_ready, mac_w, mac_x,
        input  out_valid, out_sum, out_count, out_trunc
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Streams (w,x) vectors into a clear-less MAC and returns each dot product.
// Ports: clk, rst (async active-low), bus (operands, MAC link, result).
module mac_dot_sequencer #(
    parameter int N       = 8,
    parameter int MAC_LAT = 10,
    parameter int MAX_LEN = 256,
    parameter int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    mac_dot_sequencer_if.slave bus
);
    localparam int DW = $clog2(MAC_LAT + 2);
    // One cycle beyond MAC_LAT so mac_f has settled before capture.
    localparam logic [DW-1:0] DRAIN_LD = DW'(MAC_LAT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_acc;
    logic            w_to_drain;
    logic            w_trunc_hit;
    logic [N-1:0]    r_mac_w;
    logic [N-1:0]    r_mac_x;
    logic [2*N-1:0]  r_base;
    logic [CW-1:0]   r_count;
    logic [DW-1:0]   r_drain;
    logic            r_trunc;
    logic            r_out_valid;
    logic [2*N-1:0]  r_out_sum;
    logic [CW-1:0]   r_out_count;
    logic            r_out_trunc;

    assign bus.in_ready  = rst &&
                           (r_state == S_IDLE || r_state == S_ACCUM);
    assign w_acc         = bus.in_valid && bus.in_ready;
    assign bus.mac_w     = r_mac_w;
    assign bus.mac_x     = r_mac_x;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_count = r_out_count;
    assign bus.out_trunc = r_out_trunc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_to_drain  = 1'b0;
        w_trunc_hit = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (bus.in_last || MAX_LEN == 1) begin
                        w_next      = S_DRAIN;
                        w_to_drain  = 1'b1;
                        w_trunc_hit = !bus.in_last;
                    end else begin
                        w_next = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (w_acc) begin
                    if (bus.in_last) begin
                        w_next     = S_DRAIN;
                        w_to_drain = 1'b1;
                    end else if (r_count == LAST_CNT) begin
                        w_next      = S_DRAIN;
                        w_to_drain  = 1'b1;
                        w_trunc_hit = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain == '0) w_next = S_RESULT;
            end
            S_RESULT: begin
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mac_w     <= '0;
            r_mac_x     <= '0;
            r_base      <= '0;
            r_count     <= '0;
            r_drain     <= '0;
            r_trunc     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_trunc <= 1'b0;
        end else begin
            // Zeros between beats leave the accumulator untouched.
            r_mac_w <= w_acc ? bus.in_w : '0;
            r_mac_x <= w_acc ? bus.in_x : '0;
            if (w_acc && r_state == S_IDLE) begin
                r_base  <= bus.mac_f;
                r_count <= CW'(1);
            end
            if (w_acc && r_state == S_ACCUM)
                r_count <= r_count + CW'(1);
            if (w_to_drain)  r_drain <= DRAIN_LD;
            if (w_trunc_hit) r_trunc <= 1'b1;
            if (r_state == S_DRAIN) begin
                if (r_drain != '0) begin
                    r_drain <= r_drain - DW'(1);
                end else begin
                    // Modular subtract stays correct across wrap.
                    r_out_sum   <= bus.mac_f - r_base;
                    r_out_count <= r_count;
                    r_out_trunc <= r_trunc;
                    r_out_valid <= 1'b1;
                end
            end
            if (r_state == S_RESULT && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_trunc     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with a behavioural MAC and vector model.
// Directed plan cases followed by a randomized stream.
module tb_mac_dot_sequencer;
    localparam int N       = 8;
    localparam int MAC_LAT = 10;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   acc_edge = 0;
    int   total = 0;
    int   bad = 0;

    mac_dot_sequencer_if #(.N(N), .CW(CW)) bus ();

    mac_dot_sequencer #(
        .N(N), .MAC_LAT(MAC_LAT), .MAX_LEN(MAX_LEN), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // MAC: f gains w*x MAC_LAT edges after mac_w/mac_x change.
    logic [2*N-1:0] pipe [MAC_LAT-1];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAC_LAT - 1; i++) pipe[i] <= '0;
            bus.mac_f <= '0;
        end else begin
            pipe[0] <= {{N{1'b0}}, bus.mac_w} * {{N{1'b0}}, bus.mac_x};
            for (int i = 1; i < MAC_LAT - 1; i++) pipe[i] <= pipe[i-1];
            bus.mac_f <= bus.mac_f + pipe[MAC_LAT-2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_beat(input logic [N-1:0] w, input logic [N-1:0] x,
                             input bit last);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_w     = w;
        bus.in_x     = x;
        bus.in_last  = last;
        while (!bus.in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'(bus.in_ready), 32'(1));
            bus.in_valid = 1'b0;
            return;
        end
        acc_edge = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input int e_sum,
                              input int e_cnt, input bit e_trn,
                              input int hold, input bit lat_chk);
        int g = 0;
        logic [2*N-1:0] s0;
        logic [CW-1:0]  c0;
        bus.out_ready = 1'b0;
        while (!bus.out_valid && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!bus.out_valid) begin
            check({tag, "_timeout"}, 32'(bus.out_valid), 32'(1));
            return;
        end
        if (lat_chk)
            check({tag, "_lat"}, 32'(cyc - acc_edge), 32'(MAC_LAT + 2));
        s0 = bus.out_sum;
        c0 = bus.out_count;
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_sum"}, 32'(bus.out_sum), 32'(s0));
            check({tag, "_hold_cnt"}, 32'(bus.out_count), 32'(c0));
            check({tag, "_hold_vld"}, 32'(bus.out_valid), 32'(1));
            check({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'(0));
            check({tag, "_hold_mw"},
                  32'({bus.mac_w, bus.mac_x}), 32'(0));
        end
        check({tag, "_sum"}, 32'(bus.out_sum), 32'(e_sum & 16'hFFFF));
        check({tag, "_cnt"}, 32'(bus.out_count), 32'(e_cnt));
        check({tag, "_trunc"}, 32'(bus.out_trunc), 32'(e_trn));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.out_valid), 32'(0));
    endtask

    // Reference: vectors close on last or at MAX_LEN beats.
    int qw[$], qx[$];
    bit ql[$];
    int es[$], ec[$];
    bit et[$];

    task automatic build_expected();
        int s = 0;
        int c = 0;
        for (int i = 0; i < qw.size(); i++) begin
            s = (s + qw[i] * qx[i]) % 65536;
            c++;
            if (ql[i] || c == MAX_LEN) begin
                es.push_back(s);
                ec.push_back(c);
                et.push_back(!ql[i]);
                s = 0;
                c = 0;
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_w      = '0;
        bus.in_x      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'(0));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(bus.in_ready), 32'(1));
        check("rel_outs", 32'({bus.out_sum, bus.out_count, bus.out_trunc}),
              32'(0));
        check("rel_mac", 32'({bus.mac_w, bus.mac_x}), 32'(0));
        check("rel_mac_f", 32'(bus.mac_f), 32'(0));

        // Basic vector
        send_beat(8'd3, 8'd4, 1'b0);
        send_beat(8'd5, 8'd6, 1'b0);
        send_beat(8'd7, 8'd8, 1'b1);
        get_result("basic", 98, 3, 1'b0, 0, 1'b1);

        // Baseline and wrap, with backpressure on the wrap vector
        send_beat(8'd255, 8'd255, 1'b1);
        get_result("sq", 65025, 1, 1'b0, 0, 1'b1);
        send_beat(8'd255, 8'd255, 1'b0);
        send_beat(8'd255, 8'd255, 1'b1);
        get_result("wrap", 64514, 2, 1'b0, 5, 1'b1);

        // Truncation; held 5th beat starts the next vector
        fork
            begin
                repeat (5) send_beat(8'd1, 8'd2, 1'b0);
                send_beat(8'd3, 8'd3, 1'b1);
            end
            begin
                get_result("trunc", 8, 4, 1'b1, 2, 1'b0);
                get_result("carry", 11, 2, 1'b0, 0, 1'b0);
            end
        join

        // Gaps
        send_beat(8'd2, 8'd3, 1'b0);
        idle(3);
        send_beat(8'd4, 8'd5, 1'b1);
        get_result("gap", 26, 2, 1'b0, 0, 1'b1);

        // Reset mid-vector
        send_beat(8'd9, 8'd9, 1'b0);
        send_beat(8'd7, 8'd7, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(bus.in_ready), 32'(0));
        check("mid_rst_outs",
              32'({bus.out_valid, bus.out_sum, bus.out_count}), 32'(0));
        check("mid_rst_mac", 32'({bus.mac_w, bus.mac_x}), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        begin
            int seen = 0;
            repeat (MAC_LAT + 6) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("mid_rst_novalid", 32'(seen), 32'(0));
        end
        check("mid_rst_mac_f", 32'(bus.mac_f), 32'(0));
        send_beat(8'd1, 8'd1, 1'b1);
        get_result("post_rst", 1, 1, 1'b0, 0, 1'b1);

        // Randomized stream
        for (int v = 0; v < 30; v++) begin
            int len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                qw.push_back($urandom_range(0, 255));
                qx.push_back($urandom_range(0, 255));
                ql.push_back(b == len - 1);
            end
        end
        build_expected();
        fork
            begin
                for (int i = 0; i < qw.size(); i++) begin
                    if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
                    send_beat(N'(qw[i]), N'(qx[i]), ql[i]);
                end
            end
            begin
                for (int r = 0; r < es.size(); r++)
                    get_result($sformatf("rnd%0d", r), es[r], ec[r], et[r],
                               $urandom_range(0, 3), 1'b0);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
